// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: shared state encoding and constants for the fetch sequencer.
package fetch_sequencer_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT, FAULT} state_t;
   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_BUSERR  = 2'b01;
   localparam logic [1:0] FC_TIMEOUT = 2'b10;
   localparam logic PC_SRC_SEQ = 1'b0;
   localparam logic PC_SRC_BR  = 1'b1;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: clear/enable counter flagging expiry in the cycle that would reach LIMIT.
module fetch_watchdog #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic areset,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge areset)
      if (!areset) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en) cnt <= cnt + W'(1);
   assign expired = en && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle FETCH/EXEC/UPDATE control FSM driving PC load and select.
// Define FETCH_TIMEOUT_EN to fault when a fetch waits TIMEOUT cycles without imem_ack.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             start,
   input  logic             halt_req,
   input  logic             imem_ack,
   input  logic             imem_err,
   input  logic             exec_done,
   input  logic             stall,
   input  logic             branch_taken,
   output logic             imem_req,
   output logic             instr_valid,
   output logic             pc_load,
   output logic             pc_src,
   output logic             halted,
   output logic             fault,
   output logic [1:0]       fault_cause,
   output logic [CNT_W-1:0] instret
);
   state_t state, state_d;
   logic br_q;
   logic [1:0] cause_q, cause_d;
   logic expired;
`ifdef FETCH_TIMEOUT_EN
   fetch_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .areset  (areset),
      .clr     (state != FETCH),
      .en      (state == FETCH && !imem_ack),
      .expired (expired)
   );
`else
   logic timeout_unused;
   assign timeout_unused = 1'(TIMEOUT);
   assign expired = 1'b0;
`endif
   always_ff @(posedge clk or negedge areset)
      if (!areset) begin
         state   <= IDLE;
         br_q    <= PC_SRC_SEQ;
         cause_q <= FC_NONE;
         instret <= '0;
      end else begin
         state   <= state_d;
         cause_q <= cause_d;
         if (state == EXEC && exec_done && !stall) br_q <= branch_taken;
         if (state == UPDATE) instret <= instret + CNT_W'(1);
      end
   always_comb begin
      state_d = state;
      cause_d = cause_q;
      case (state)
         IDLE:   state_d = start ? FETCH : IDLE;
         FETCH:
            if (imem_ack) begin
               state_d = imem_err ? FAULT : EXEC;
               cause_d = imem_err ? FC_BUSERR : cause_q;
            end else if (expired) begin
               state_d = FAULT;
               cause_d = FC_TIMEOUT;
            end
         EXEC:   state_d = (exec_done && !stall) ? UPDATE : EXEC;
         UPDATE: state_d = halt_req ? HALT : FETCH;
         HALT:   state_d = start ? FETCH : HALT;
         FAULT:  state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end
   assign imem_req    = state == FETCH;
   assign instr_valid = state == EXEC;
   assign pc_load     = state == UPDATE;
   assign pc_src      = pc_load ? br_q : PC_SRC_SEQ;
   assign halted      = state == HALT;
   assign fault       = state == FAULT;
   assign fault_cause = cause_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized per-instruction latency checks of fetch_sequencer.
module tb_fetch_sequencer;
   logic clk = 1'b0, areset = 1'b0, start = 1'b0, halt_req = 1'b0;
   logic imem_ack = 1'b0, imem_err = 1'b0, exec_done = 1'b0, stall = 1'b0, branch_taken = 1'b0;
   logic imem_req, instr_valid, pc_load, pc_src, halted, fault;
   logic [1:0] fault_cause;
   logic [31:0] instret;
   int checks = 0, errors = 0, exp_cnt = 0;

   fetch_sequencer #(.CNT_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .areset(areset), .start(start), .halt_req(halt_req),
      .imem_ack(imem_ack), .imem_err(imem_err), .exec_done(exec_done), .stall(stall),
      .branch_taken(branch_taken), .imem_req(imem_req), .instr_valid(instr_valid),
      .pc_load(pc_load), .pc_src(pc_src), .halted(halted), .fault(fault),
      .fault_cause(fault_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // One instruction from a FETCH-state sample point: ad idle fetch cycles before ack,
   // ed exec cycles before exec_done, sc further cycles of exec_done held off by stall.
   task automatic run_instr(input int ad, input int ed, input int sc, input logic br, input logic hr);
      chk("fetch_req", 32'(imem_req), 1);
      chk("fetch_noload", 32'(pc_load), 0);
      for (int i = 0; i <= ad; i++) begin
         if (i > 0) begin
            chk("fetch_hold", 32'(imem_req), 1);
            chk("fetch_iv", 32'(instr_valid), 0);
         end
         imem_ack = (i == ad);
         imem_err = (i == ad) ? 1'b0 : 1'($urandom);
         exec_done = 1'($urandom);
         stall = 1'($urandom);
         branch_taken = 1'($urandom);
         halt_req = 1'($urandom);
         start = 1'($urandom);
         tick;
      end
      imem_ack = 1'b0; imem_err = 1'b0; start = 1'b0;
      for (int j = 0; j <= ed + sc; j++) begin
         chk("exec_iv", 32'(instr_valid), 1);
         chk("exec_noload", 32'(pc_load), 0);
         chk("exec_noreq", 32'(imem_req), 0);
         exec_done = (j >= ed);
         stall = (j >= ed) ? (j < ed + sc) : 1'($urandom);
         branch_taken = (j == ed + sc) ? br : 1'($urandom);
         imem_ack = 1'($urandom);
         halt_req = 1'($urandom);
         tick;
      end
      exec_done = 1'b0; stall = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0;
      chk("upd_load", 32'(pc_load), 1);
      chk("upd_src", 32'(pc_src), 32'(br));
      chk("upd_instret", instret, 32'(exp_cnt));
      halt_req = hr;
      tick;
      exp_cnt++;
      halt_req = 1'b0;
      chk("post_instret", instret, 32'(exp_cnt));
      chk("post_noload", 32'(pc_load), 0);
      chk("post_src", 32'(pc_src), 0);
      if (hr) begin
         for (int k = 0; k < 2; k++) begin
            chk("halted", 32'(halted), 1);
            chk("halt_noreq", 32'(imem_req), 0);
            chk("halt_noload", 32'(pc_load), 0);
            imem_ack = 1'($urandom);
            exec_done = 1'($urandom);
            tick;
         end
         start = 1'b1; halt_req = 1'b1;
         tick;
         start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
         chk("resume_req", 32'(imem_req), 1);
         chk("resume_halted", 32'(halted), 0);
         chk("resume_instret", instret, 32'(exp_cnt));
      end else
         chk("next_fetch", 32'(imem_req), 1);
   endtask

   initial begin
      int n;
      #12;
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_iv", 32'(instr_valid), 0);
      chk("rst_load", 32'(pc_load), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_instret", instret, 0);
      areset = 1'b1;
      tick;
      chk("idle_req", 32'(imem_req), 0);
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (4) run_instr(0, 0, 0, 1'b0, 1'b0);
      chk("instret_4", instret, 4);
      run_instr(0, 0, 0, 1'b1, 1'b0);
      run_instr(0, 0, 0, 1'b0, 1'b0);
      run_instr(0, 0, 5, 1'b0, 1'b0);
      run_instr(3, 0, 0, 1'b1, 1'b0);
      run_instr(1, 2, 0, 1'b0, 1'b1);
      repeat (40)
         run_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), $urandom_range(0, 5) == 0);

      // asynchronous reset while an instruction is in EXEC
      imem_ack = 1'b1;
      tick;
      imem_ack = 1'b0;
      chk("pre_rst_exec", 32'(instr_valid), 1);
      #2 areset = 1'b0;
      #1;
      chk("arst_iv", 32'(instr_valid), 0);
      chk("arst_load", 32'(pc_load), 0);
      chk("arst_req", 32'(imem_req), 0);
      chk("arst_instret", instret, 0);
      exp_cnt = 0;
      tick;
      areset = 1'b1;
      tick;
      chk("arst_idle", 32'(imem_req), 0);

      // bus error fault is sticky until reset
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("flt_fetch", 32'(imem_req), 1);
      imem_ack = 1'b1; imem_err = 1'b1;
      tick;
      imem_ack = 1'b0; imem_err = 1'b0;
      chk("flt_flag", 32'(fault), 1);
      chk("flt_cause", 32'(fault_cause), 1);
      chk("flt_noreq", 32'(imem_req), 0);
      repeat (3) begin
         start = 1'b1; halt_req = 1'b1; exec_done = 1'b1; imem_ack = 1'($urandom);
         tick;
         chk("flt_hold", 32'(fault), 1);
         chk("flt_noload", 32'(pc_load), 0);
         chk("flt_cause_hold", 32'(fault_cause), 1);
      end
      start = 1'b0; halt_req = 1'b0; exec_done = 1'b0; imem_ack = 1'b0;
      areset = 1'b0;
      #1;
      chk("flt_clr", 32'(fault), 0);
      chk("flt_cause_clr", 32'(fault_cause), 0);
      tick;
      areset = 1'b1;

      start = 1'b1;
      tick;
      start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      n = 0;
      while (imem_req === 1'b1 && n < 10) begin
         n++;
         imem_err = 1'($urandom);
         tick;
      end
      imem_err = 1'b0;
      chk("to_cycles", 32'(n), 4);
      chk("to_fault", 32'(fault), 1);
      chk("to_cause", 32'(fault_cause), 2);
`else
      n = 0;
      repeat (20) begin
         chk("wait_req", 32'(imem_req), 1);
         chk("wait_nofault", 32'(fault), 0);
         imem_err = 1'($urandom);
         tick;
         n++;
      end
      imem_err = 1'b0;
      imem_ack = 1'b1;
      tick;
      imem_ack = 1'b0;
      chk("late_ack_exec", 32'(instr_valid), 1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
